// File: rtl/uart_frame_serializer.sv
// Frame-to-byte serializer: streams up to N_BYTES bytes of a parallel frame into a
// byte-wide UART transmitter, with a one-frame shadow buffer for back-to-back loads.
module uart_frame_serializer #(
   parameter int N_BYTES     = 51,
   parameter int MSB_FIRST   = 1,
   parameter int ACK_TIMEOUT = 4,
   parameter int LW          = $clog2(N_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8*N_BYTES-1:0]   data_in,
   input  logic [LW-1:0]          len_in,
   input  logic                   load,
   input  logic                   tx_busy,
   output logic [7:0]             tx_data,
   output logic                   tx_send,
   output logic                   ready,
   output logic                   active,
   output logic                   done,
   output logic                   overflow
);

   localparam int FW = 8 * N_BYTES;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [LW-1:0] LEN_MAX = LW'(N_BYTES);
   localparam logic [TW-1:0] TO_MAX  = TW'(ACK_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [FW-1:0]   r_work;
   logic [LW-1:0]   r_cnt;
   logic [FW-1:0]   r_sh_data;
   logic [LW-1:0]   r_sh_len;
   logic            r_sh_valid;
   logic [TW-1:0]   r_to;
   logic [7:0]      r_tx_data;
   logic            r_tx_send;
   logic            r_done;
   logic            r_overflow;

   logic [LW-1:0]   w_len_clamped;
   logic [7:0]      w_head;
   logic [FW-1:0]   w_shifted;
   logic [TW-1:0]   w_to_inc;
   logic            w_take_in;
   logic            w_take_sh;
   logic            w_sh_set;
   logic            w_sh_clr;
   logic            w_ovf_set;
   logic            w_send;
   logic            w_done;
   logic            w_to_step;

   assign w_len_clamped = (len_in == '0 || len_in > LEN_MAX) ? LEN_MAX : len_in;
   assign w_to_inc      = r_to + TW'(1);

   generate
      if (MSB_FIRST != 0) begin : g_msb
         assign w_head    = r_work[FW-1 -: 8];
         assign w_shifted = {r_work[FW-9:0], 8'h00};
      end else begin : g_lsb
         assign w_head    = r_work[7:0];
         assign w_shifted = {8'h00, r_work[FW-1:8]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_take_in    = 1'b0;
      w_take_sh    = 1'b0;
      w_sh_set     = 1'b0;
      w_sh_clr     = 1'b0;
      w_ovf_set    = 1'b0;
      w_send       = 1'b0;
      w_done       = 1'b0;
      w_to_step    = 1'b0;
      case (r_state)
         IDLE: begin
            // A pending shadow frame always goes out before a newly loaded one.
            if (load) begin
               w_state_next = SEND;
               if (r_sh_valid) begin
                  w_take_sh = 1'b1;
                  w_sh_set  = 1'b1;
               end else begin
                  w_take_in = 1'b1;
               end
            end else if (r_sh_valid) begin
               w_take_sh    = 1'b1;
               w_sh_clr     = 1'b1;
               w_state_next = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               w_send       = 1'b1;
               w_state_next = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy) begin
               w_state_next = WAIT_LO;
            end else begin
               w_to_step = 1'b1;
               if (w_to_inc == TO_MAX) begin
                  w_state_next = WAIT_LO;
               end
            end
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               if (r_cnt != '0) begin
                  w_state_next = SEND;
               end else begin
                  w_done = 1'b1;
                  if (r_sh_valid) begin
                     w_take_sh    = 1'b1;
                     w_sh_clr     = 1'b1;
                     w_state_next = SEND;
                  end else if (load) begin
                     // Load coinciding with completion starts immediately, no IDLE cycle.
                     w_take_in    = 1'b1;
                     w_state_next = SEND;
                  end else begin
                     w_state_next = IDLE;
                  end
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
      if (load && r_state != IDLE && !w_take_in) begin
         if (!r_sh_valid || w_sh_clr) begin
            w_sh_set = 1'b1;
         end else begin
            w_ovf_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work     <= '0;
         r_cnt      <= '0;
         r_sh_data  <= '0;
         r_sh_len   <= '0;
         r_sh_valid <= 1'b0;
         r_to       <= '0;
         r_tx_data  <= 8'h00;
         r_tx_send  <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_take_in) begin
            r_work <= data_in;
            r_cnt  <= w_len_clamped;
         end else if (w_take_sh) begin
            r_work <= r_sh_data;
            r_cnt  <= r_sh_len;
         end else if (w_send) begin
            r_work    <= w_shifted;
            r_cnt     <= r_cnt - LW'(1);
            r_tx_data <= w_head;
         end
         r_tx_send <= w_send;
         r_done    <= w_done;
         if (w_send) begin
            r_to <= '0;
         end else if (w_to_step) begin
            r_to <= w_to_inc;
         end
         if (w_sh_set) begin
            r_sh_data  <= data_in;
            r_sh_len   <= w_len_clamped;
            r_sh_valid <= 1'b1;
         end else if (w_sh_clr) begin
            r_sh_valid <= 1'b0;
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign tx_data  = r_tx_data;
   assign tx_send  = r_tx_send;
   assign done     = r_done;
   assign overflow = r_overflow;
   assign ready    = ~r_sh_valid;
   assign active   = (r_state != IDLE);

endmodule
